// File: rtl/wb_regfile_if.sv
// wb_regfile_if: groups the ME->WB commit signals, the two ID-stage read
// ports and the debug outputs of the write-back / register-file block.
// The master drives the pipeline-register values and read addresses. The
// slave (wb_regfile) returns the read data, the selected write-back data
// and the retired-write count.
interface wb_regfile_if;
  logic [31:0] ans_wb;    // ALU result from the ME->WB register
  logic [31:0] mo_wb;     // memory read data from the ME->WB register
  logic [4:0]  rw_wb;     // destination register number
  logic        wreg_wb;   // register-write enable
  logic        m2reg_wb;  // 1: commit mo_wb, 0: commit ans_wb
  logic [4:0]  rna;       // read port A register number (rs)
  logic [4:0]  rnb;       // read port B register number (rt)
  logic [31:0] qa;        // read port A data
  logic [31:0] qb;        // read port B data
  logic [31:0] wdata_wb;  // selected write-back data, also used for forwarding
  logic [31:0] wb_count;  // count of effective register writes

  modport master (
    output ans_wb, mo_wb, rw_wb, wreg_wb, m2reg_wb, rna, rnb,
    input  qa, qb, wdata_wb, wb_count
  );

  modport slave (
    input  ans_wb, mo_wb, rw_wb, wreg_wb, m2reg_wb, rna, rnb,
    output qa, qb, wdata_wb, wb_count
  );
endinterface : wb_regfile_if

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and 32x32 architectural register file of the
// 5-stage MIPS pipeline. It selects the ALU result or the memory data and
// commits it to the array. It also counts the committed writes.
// Register 0 reads as zero, and writes to it are discarded and not counted.
// Reset is synchronous and active-high. It clears the array and the counter,
// and it wins over a write presented in the same cycle.
//
// Build option:
//   WB_BYPASS_EN  When defined, a read of the register being written in the
//                 current cycle returns the new data. This is the same-cycle
//                 write-through. When undefined, reads always return the
//                 array contents.
module wb_regfile (
  input  logic       clock,
  input  logic       reset,
  wb_regfile_if.slave bus
);

  logic [31:0] r_regs [0:31];
  logic [31:0] r_wb_count;

  logic [31:0] w_wdata;
  logic        w_we_eff;
  logic [31:0] w_qa;
  logic [31:0] w_qb;

  // Write-back data is always presented, even for bubbles, because the
  // forwarding network consumes it whether or not a write commits.
  assign w_wdata  = bus.m2reg_wb ? bus.mo_wb : bus.ans_wb;

  // A write only commits for a nonzero destination outside of reset.
  assign w_we_eff = bus.wreg_wb && (bus.rw_wb != 5'd0) && !reset;

  // Register array: synchronous clear on reset, otherwise the committed write.
  // NOTE: the array has a reset because every register must read zero after reset. This keeps it in flops rather than a RAM macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we_eff) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      r_regs[bus.rw_wb] <= w_wdata;
    end
  end

  // Retired-write counter. It wraps modulo 2^32 and advances on the same
  // edge as the array write.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb_count <= '0;
    end else if (w_we_eff) begin
      r_wb_count <= r_wb_count + 32'd1;
    end
  end

  // Asynchronous read ports. Register 0 is forced to zero. With the bypass
  // built in, a read of the register being written returns the new data.
  always_comb begin
    // NOTE: both outputs get a default first so no path leaves them unassigned (no latch).
    w_qa = '0;
    w_qb = '0;
    if (bus.rna != 5'd0) begin
      w_qa = r_regs[bus.rna];
    end
    if (bus.rnb != 5'd0) begin
      w_qb = r_regs[bus.rnb];
    end
`ifdef WB_BYPASS_EN
    // w_we_eff already excludes r0, so a bypass never makes r0 nonzero.
    if (w_we_eff && (bus.rna == bus.rw_wb)) begin
      w_qa = w_wdata;
    end
    if (w_we_eff && (bus.rnb == bus.rw_wb)) begin
      w_qb = w_wdata;
    end
`else
    // No write-through: the new data becomes visible after the edge.
`endif
  end

  assign bus.qa       = w_qa;
  assign bus.qb       = w_qb;
  assign bus.wdata_wb = w_wdata;
  assign bus.wb_count = r_wb_count;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed plus random stimulus for wb_regfile. An abstract
// architectural model (an array and a write count) predicts qa, qb, wdata_wb
// and wb_count, and is compared on every falling edge after the first reset.
// Directed steps also compare the DUT against hand-computed literals.
// Honours WB_BYPASS_EN in the same way as the design.
module tb_wb_regfile;

  logic clock;
  logic reset;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural model: the register contents and the number of retired writes.
  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  bit          m_valid = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_count <= 32'd0;
      m_valid <= 1'b1;
    end else if (bus.wreg_wb && bus.rw_wb != 5'd0) begin
      m_regs[bus.rw_wb] <= bus.m2reg_wb ? bus.mo_wb : bus.ans_wb;
      m_count           <= m_count + 32'd1;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] rn);
    logic [31:0] wd;
    wd = bus.m2reg_wb ? bus.mo_wb : bus.ans_wb;
    if (rn == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (bus.wreg_wb && !reset && rn == bus.rw_wb) return wd;
`endif
    return m_regs[rn];
  endfunction

  // Continuous comparison against the model, mid-cycle.
  always @(negedge clock) begin
    if (m_valid) begin
      check("model_qa",    bus.qa,       exp_read(bus.rna));
      check("model_qb",    bus.qb,       exp_read(bus.rnb));
      check("model_wdata", bus.wdata_wb, bus.m2reg_wb ? bus.mo_wb : bus.ans_wb);
      check("model_count", bus.wb_count, m_count);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset held for two edges while a write to r5 is presented.
    reset        = 1'b1;
    bus.wreg_wb  = 1'b1;
    bus.rw_wb    = 5'd5;
    bus.ans_wb   = 32'h0000_1234;
    bus.mo_wb    = 32'h0;
    bus.m2reg_wb = 1'b0;
    bus.rna      = 5'd0;
    bus.rnb      = 5'd0;
    step();
    step();
    reset       = 1'b0;
    bus.wreg_wb = 1'b0;
    bus.rna     = 5'd5;
    #1;
    check("reset_qa_r5", bus.qa, 32'h0);
    check("reset_count", bus.wb_count, 32'h0);

    // Select the ALU result.
    bus.rw_wb    = 5'd3;
    bus.wreg_wb  = 1'b1;
    bus.m2reg_wb = 1'b0;
    bus.ans_wb   = 32'hAAAA_0001;
    bus.mo_wb    = 32'h5555_0002;
    #1;
    check("wdata_alu", bus.wdata_wb, 32'hAAAA_0001);
    step();
    bus.wreg_wb = 1'b0;
    bus.rna     = 5'd3;
    #1;
    check("sel_alu_qa",    bus.qa,       32'hAAAA_0001);
    check("sel_alu_count", bus.wb_count, 32'd1);

    // Select the memory data.
    bus.wreg_wb  = 1'b1;
    bus.m2reg_wb = 1'b1;
    #1;
    check("wdata_mem", bus.wdata_wb, 32'h5555_0002);
    step();
    bus.wreg_wb = 1'b0;
    #1;
    check("sel_mem_qa",    bus.qa,       32'h5555_0002);
    check("sel_mem_count", bus.wb_count, 32'd2);

    // r0 protection, including the bypass path.
    bus.wreg_wb  = 1'b1;
    bus.rw_wb    = 5'd0;
    bus.m2reg_wb = 1'b0;
    bus.ans_wb   = 32'hFFFF_FFFF;
    bus.rna      = 5'd0;
    bus.rnb      = 5'd0;
    #1;
    check("r0_qa_same_cycle", bus.qa, 32'h0);
    step();
    bus.wreg_wb = 1'b0;
    #1;
    check("r0_qa_after",  bus.qa,       32'h0);
    check("r0_count",     bus.wb_count, 32'd2);

    // Read r7 on both ports in the cycle it is written.
    bus.rw_wb   = 5'd7;
    bus.ans_wb  = 32'hDEAD_BEEF;
    bus.wreg_wb = 1'b1;
    bus.rna     = 5'd7;
    bus.rnb     = 5'd7;
    #1;
`ifdef WB_BYPASS_EN
    check("bypass_qa", bus.qa, 32'hDEAD_BEEF);
    check("bypass_qb", bus.qb, 32'hDEAD_BEEF);
`else
    check("nobypass_qa", bus.qa, 32'h0);
    check("nobypass_qb", bus.qb, 32'h0);
`endif
    step();
    bus.wreg_wb = 1'b0;
    #1;
    check("r7_after_qa", bus.qa,       32'hDEAD_BEEF);
    check("r7_after_qb", bus.qb,       32'hDEAD_BEEF);
    check("r7_count",    bus.wb_count, 32'd3);

    // With wreg_wb low, nothing is written for three cycles.
    bus.rw_wb  = 5'd9;
    bus.ans_wb = 32'h0000_0077;
    bus.rna    = 5'd9;
    step();
    step();
    step();
    check("nowrite_qa",    bus.qa,       32'h0);
    check("nowrite_count", bus.wb_count, 32'd3);

    // Write r4, then assert reset in the same cycle as another r4 write.
    bus.rw_wb   = 5'd4;
    bus.ans_wb  = 32'h0000_0044;
    bus.wreg_wb = 1'b1;
    step();
    bus.wreg_wb = 1'b0;
    bus.rna     = 5'd4;
    #1;
    check("r4_before_reset", bus.qa,       32'h0000_0044);
    check("count_pre_reset", bus.wb_count, 32'd4);
    reset       = 1'b1;
    bus.wreg_wb = 1'b1;
    bus.ans_wb  = 32'h0000_0099;
    #1;
    check("r4_during_reset", bus.qa, 32'h0000_0044);
    step();
    reset       = 1'b0;
    bus.wreg_wb = 1'b0;
    #1;
    check("r4_after_reset", bus.qa,       32'h0);
    check("count_reset",    bus.wb_count, 32'h0);

    // Random traffic with occasional resets. The model checks every cycle.
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 49) == 0);
      bus.wreg_wb  = ($urandom_range(0, 3) != 0);
      bus.m2reg_wb = $urandom_range(0, 1) != 0;
      bus.rw_wb    = 5'($urandom_range(0, 7));
      bus.rna      = 5'($urandom_range(0, 7));
      bus.rnb      = ($urandom_range(0, 3) == 0) ? bus.rw_wb : 5'($urandom_range(0, 7));
      bus.ans_wb   = $urandom;
      bus.mo_wb    = $urandom;
      step();
    end
    reset       = 1'b0;
    bus.wreg_wb = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_regfile
